mem_tester: RTL



---
 rtl/mem_tester_if.sv | 28 ++
 rtl/mem_tester.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_tester_if.sv
// Memory-system bus shared by the tester (initiator) and the RAM window (responder).
// The data lines are resolved here: the initiator owns them only during write
// cycles, the responder only while it enables its read driver.
interface mem_tester_if;
  logic [15:0] address;
  logic        read_write_sel;
  logic [7:0]  wdata;
  logic [7:0]  rsp_data;
  logic        rsp_oe;
  wire  [7:0]  data;

  assign data = (!read_write_sel) ? wdata : (rsp_oe ? rsp_data : 8'hzz);

  modport master (
    output address,
    output read_write_sel,
    output wdata,
    input  data
  );

  modport slave (
    input  address,
    input  read_write_sel,
    input  data,
    output rsp_data,
    output rsp_oe
  );
endinterface

// File: rtl/mem_tester.sv
// mem_tester: writes seed ^ addr[7:0] to a contiguous byte range, then reads
// every byte back (two cycles per byte) and reports pass / error count /
// first failing address. Drives the same bus the 6502 core uses.
module mem_tester #(
  parameter int LEN_W = 13
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       seed,
  mem_tester_if.master     bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       error_count,
  output logic [15:0]      first_fail_addr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RD_CHECK = 2'd3
  } state_e;

  // Test pattern for one byte: depends only on the seed and the low address byte.
  function automatic logic [7:0] pattern_byte(input logic [7:0] s, input logic [15:0] a);
    return s ^ a[7:0];
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic             rws_q, rws_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [15:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       seed_q, seed_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      ffa_q, ffa_d;

  logic [15:0]      addr_inc;
  logic [LEN_W-1:0] cnt_inc;
  logic             last_rd;
  logic             rd_mismatch;
  logic [7:0]       err_inc;

  assign addr_inc    = addr_q + 16'd1;
  assign cnt_inc     = cnt_q + LEN_W'(1);
  assign last_rd     = (cnt_q == (len_q - LEN_W'(1)));
  assign rd_mismatch = (bus.data != pattern_byte(seed_q, addr_q));
  assign err_inc     = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);

  // Next-state and next-output logic for the write / read-back sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rws_d   = rws_q;
    wdata_d = wdata_q;
    base_d  = base_q;
    len_d   = len_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    ffa_d   = ffa_q;

    case (state_q)
      S_IDLE: begin
        rws_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          base_d = base_addr;
          len_d  = length;
          seed_d = seed;
          err_d  = 8'h00;
          ffa_d  = 16'h0000;
          if (length == {LEN_W{1'b0}}) begin
            // Empty test: report success immediately, bus stays parked.
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            addr_d  = base_addr;
            wdata_d = pattern_byte(seed, base_addr);
            rws_d   = 1'b0;
            cnt_d   = LEN_W'(1);
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WRITE: begin
        if (cnt_q == len_q) begin
          // All bytes issued: present the first read address, release data.
          addr_d  = base_q;
          rws_d   = 1'b1;
          cnt_d   = {LEN_W{1'b0}};
          state_d = S_RD_WAIT;
        end else begin
          addr_d  = addr_inc;
          wdata_d = pattern_byte(seed_q, addr_inc);
          cnt_d   = cnt_inc;
          state_d = S_WRITE;
        end
      end

      S_RD_WAIT: begin
        state_d = S_RD_CHECK;
      end

      S_RD_CHECK: begin
        if (rd_mismatch) begin
          err_d = err_inc;
          if (err_q == 8'h00) begin
            ffa_d = addr_q;
          end else begin
            ffa_d = ffa_q;
          end
        end else begin
          err_d = err_q;
        end
        if (last_rd) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'h00);
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_inc;
          cnt_d   = cnt_inc;
          state_d = S_RD_WAIT;
        end
      end

      default: begin
        rws_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset parks the bus in read mode.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      rws_q   <= 1'b1;
      wdata_q <= 8'h00;
      base_q  <= 16'h0000;
      len_q   <= {LEN_W{1'b0}};
      seed_q  <= 8'h00;
      cnt_q   <= {LEN_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'h00;
      ffa_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rws_q   <= rws_d;
      wdata_q <= wdata_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
    end
  end

  assign bus.address        = addr_q;
  assign bus.read_write_sel = rws_q;
  assign bus.wdata          = wdata_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign error_count        = err_q;
  assign first_fail_addr    = ffa_q;

endmodule
